// File: rtl/i2c_ccd_write_arbiter_pkg.sv
// Shared types and constants for the sensor I2C write arbiter.
package i2c_ccd_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [7:0] SENSOR_WR_ADDR = 8'hBA;
  localparam int         I2C_WORD_W     = 24;
  localparam int         REG_WORD_W     = 16;

endpackage

// File: rtl/i2c_tick_gen.sv
// Control-clock divider; tick marks the iCLK cycle in which ctrl_clk is about to rise.
// Free-running, no backpressure; ctrl_clk toggles every DIV+1 iCLK cycles.
module i2c_tick_gen #(
  parameter int DIV = 2500
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic ctrl_clk,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV));
  assign tick = wrap && !ctrl_clk;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt      <= '0;
      ctrl_clk <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      ctrl_clk <= ~ctrl_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_ccd_write_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller among register-write requesters, with NACK retry and END timeout.
// Idle request reaches GO within 2 control ticks; requesters hold iREQ until their DONE/ERR pulse.
module i2c_ccd_write_arbiter
  import i2c_ccd_write_arbiter_pkg::*;
#(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         I2C_FREQ      = 20000,
  parameter int         NUM_REQ       = 4,
  parameter logic [7:0] SLAVE_ADDR    = SENSOR_WR_ADDR,
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT_TICKS = 64
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic [NUM_REQ-1:0]            iREQ,
  input  logic [REG_WORD_W*NUM_REQ-1:0] iREQ_DATA,
  output logic [NUM_REQ-1:0]            oGNT,
  output logic [NUM_REQ-1:0]            oDONE,
  output logic [NUM_REQ-1:0]            oERR,
  output logic                          oBUSY,
  output logic                          oI2C_CTRL_CLK,
  output logic [I2C_WORD_W-1:0]         oI2C_DATA,
  output logic                          oI2C_GO,
  input  logic                          iI2C_END,
  input  logic                          iI2C_ACK
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  state_t                  state;
  logic                    tick;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        gnt_idx;
  logic [RTY_W-1:0]        retry;
  logic [TO_W-1:0]         to_cnt;
  logic [REG_WORD_W-1:0]   word;
  logic                    finish;
  logic                    found;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        cand;

  i2c_tick_gen #(
    .DIV(CLK_FREQ / I2C_FREQ)
  ) u_tick (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .ctrl_clk(oI2C_CTRL_CLK),
    .tick    (tick)
  );

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && iREQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign oBUSY = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      retry     <= '0;
      to_cnt    <= '0;
      word      <= '0;
      finish    <= 1'b0;
      oGNT      <= '0;
      oDONE     <= '0;
      oERR      <= '0;
      oI2C_DATA <= '0;
      oI2C_GO   <= 1'b0;
    end else begin
      oDONE <= '0;
      oERR  <= '0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (found) begin
              gnt_idx    <= pick;
              word       <= iREQ_DATA[REG_WORD_W*pick +: REG_WORD_W];
              oGNT       <= '0;
              oGNT[pick] <= 1'b1;
              retry      <= '0;
              state      <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            oI2C_DATA <= {SLAVE_ADDR, word};
            oI2C_GO   <= 1'b1;
            to_cnt    <= '0;
            state     <= ST_WAIT;
          end
          ST_WAIT: begin
            if (iI2C_END && !iI2C_ACK) begin
              oI2C_GO        <= 1'b0;
              oDONE[gnt_idx] <= 1'b1;
              finish         <= 1'b1;
              state          <= ST_GAP;
            end else if (iI2C_END || to_cnt == TO_W'(TIMEOUT_TICKS)) begin
              // A missing END is handled exactly like a NACK.
              oI2C_GO <= 1'b0;
              if (retry < RTY_W'(MAX_RETRY)) begin
                retry  <= retry + 1'b1;
                finish <= 1'b0;
              end else begin
                oERR[gnt_idx] <= 1'b1;
                finish        <= 1'b1;
              end
              state <= ST_GAP;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (!finish) begin
              state <= ST_ISSUE;
            end else begin
              oGNT   <= '0;
              rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_ccd_write_arbiter.sv
// Directed bench with a completion scoreboard and a simple I2C_Controller responder model.
module tb_i2c_ccd_write_arbiter;

  localparam int DIV    = 4;
  localparam int PERIOD = 2 * (DIV + 1);

  logic        iCLK;
  logic        iRST_N;
  logic [3:0]  iREQ;
  logic [63:0] iREQ_DATA;
  logic [3:0]  oGNT, oDONE, oERR;
  logic        oBUSY, oI2C_CTRL_CLK, oI2C_GO;
  logic [23:0] oI2C_DATA;
  logic        iI2C_END, iI2C_ACK;

  i2c_ccd_write_arbiter #(
    .CLK_FREQ     (40),
    .I2C_FREQ     (10),
    .NUM_REQ      (4),
    .SLAVE_ADDR   (8'hBA),
    .MAX_RETRY    (3),
    .TIMEOUT_TICKS(64)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iREQ         (iREQ),
    .iREQ_DATA    (iREQ_DATA),
    .oGNT         (oGNT),
    .oDONE        (oDONE),
    .oERR         (oERR),
    .oBUSY        (oBUSY),
    .oI2C_CTRL_CLK(oI2C_CTRL_CLK),
    .oI2C_DATA    (oI2C_DATA),
    .oI2C_GO      (oI2C_GO),
    .iI2C_END     (iI2C_END),
    .iI2C_ACK     (iI2C_ACK)
  );

  typedef struct {
    int          idx;
    bit          err;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          resp_q[$];   // 0 = ACK, 1 = NACK, 2 = never END
  int          n_chk  = 0;
  int          n_fail = 0;
  int          go_total = 0;
  int          low_cnt = 0;
  bit          seen_low = 0;
  bit          go_prev = 0;
  bit          chk_width = 0;
  logic [15:0] w [4];

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_empty(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_go(input int budget, input string tag, output int lat);
    lat = 0;
    while (!oI2C_GO && lat < budget) begin
      @(negedge iCLK);
      lat++;
    end
    check(tag, oI2C_GO, 1);
  endtask

  task automatic push(input int idx, input bit err);
    exp_t e;
    e.idx  = idx;
    e.err  = err;
    e.word = w[idx];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  // Controller model: answers each GO after a short delay, then releases END once GO drops.
  initial begin
    int r;
    iI2C_END = 1'b0;
    iI2C_ACK = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oI2C_GO) begin
        r = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
        for (int k = 0; k < 15 && oI2C_GO; k++) @(negedge iCLK);
        if (oI2C_GO && r != 2) begin
          iI2C_ACK = (r == 1);
          iI2C_END = 1'b1;
        end
        while (oI2C_GO) @(negedge iCLK);
        iI2C_END = 1'b0;
        iI2C_ACK = 1'b0;
      end
    end
  end

  // Monitor: GO payload and spacing, completion pulses against the scoreboard.
  always @(negedge iCLK) begin
    exp_t e;
    if (chk_width) begin
      check("pulse_width", {oDONE, oERR}, 0);
      chk_width = 0;
    end
    if (oDONE != 0 || oERR != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {oDONE, oERR}, 0);
      end else begin
        e = exp_q.pop_front();
        check(e.err ? "err_src" : "done_src", e.err ? oERR : oDONE, onehot(e.idx));
        check("pulse_other_kind", e.err ? oDONE : oERR, 0);
        check("gnt_at_pulse", oGNT, onehot(e.idx));
      end
      chk_width = 1;
    end
    if (oI2C_GO && !go_prev) begin
      go_total++;
      if (seen_low) check("go_low_gap_ok", low_cnt >= PERIOD, 1);
      if (exp_q.size() != 0) check("go_data", oI2C_DATA, {8'hBA, exp_q[0].word});
      else check("go_unexpected", 1, 0);
    end
    if (!oI2C_GO && go_prev) begin
      seen_low = 1;
      low_cnt  = 0;
    end
    if (!oI2C_GO) low_cnt++;
    go_prev = oI2C_GO;
  end

  initial begin
    int lat;
    int go0;
    w[0] = 16'h2000;
    w[1] = 16'h3A5C;
    w[2] = 16'hF103;
    w[3] = 16'h0B77;
    iREQ      = 4'b0000;
    iREQ_DATA = {w[3], w[2], w[1], w[0]};
    iRST_N    = 1'b0;

    // Reset state
    repeat (3) @(negedge iCLK);
    check("rst_gnt", oGNT, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_go", oI2C_GO, 0);
    check("rst_data", oI2C_DATA, 0);
    check("rst_ctrl_clk", oI2C_CTRL_CLK, 0);
    check("rst_pulses", {oDONE, oERR}, 0);
    iRST_N = 1'b1;
    repeat (7) @(negedge iCLK);

    // Single write from requester 0
    go0 = go_total;
    push(0, 0);
    iREQ = 4'b0001;
    wait_go(60, "single_go_seen", lat);
    check("single_latency_ok", lat <= 2 * PERIOD + 1, 1);
    check("single_busy", oBUSY, 1);
    wait_empty(400, "single_done");
    iREQ = 4'b0000;
    repeat (3 * PERIOD) @(negedge iCLK);
    check("single_gnt_clear", oGNT, 0);
    check("single_busy_clear", oBUSY, 0);
    check("single_go_count", go_total - go0, 1);

    // Two NACKs then ACK: three GOs, one DONE
    go0 = go_total;
    resp_q = '{1, 1, 0};
    push(2, 0);
    iREQ = 4'b0100;
    wait_empty(1000, "retry_done");
    iREQ = 4'b0000;
    check("retry_go_count", go_total - go0, 3);

    // Retries exhausted on requester 0, then requester 1 is served
    go0 = go_total;
    resp_q = '{1, 1, 1, 1};
    push(0, 1);
    push(1, 0);
    iREQ = 4'b0011;
    begin
      int n = 0;
      while (exp_q.size() > 1 && n < 2000) begin
        @(negedge iCLK);
        n++;
      end
    end
    iREQ = 4'b0010;
    wait_empty(1000, "exhaust_next_served");
    iREQ = 4'b0000;
    check("exhaust_go_count", go_total - go0, 5);

    // No END ever: timeout on every attempt
    go0 = go_total;
    resp_q = '{2, 2, 2, 2};
    push(3, 1);
    iREQ = 4'b1000;
    wait_empty(4000, "timeout_err");
    iREQ = 4'b0000;
    check("timeout_go_count", go_total - go0, 4);

    // Round robin with held requests from rr_ptr = 0
    repeat (2 * PERIOD) @(negedge iCLK);
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(0, 0);
      push(1, 0);
      push(3, 0);
    end
    iREQ = 4'b1011;
    wait_empty(2000, "rr_sequence");
    iREQ = 4'b0000;
    repeat (3 * PERIOD) @(negedge iCLK);
    check("rr_idle_busy", oBUSY, 0);

    // Reset during WAIT, then restart from requester 0
    resp_q = '{2};
    push(2, 0);
    iREQ = 4'b0100;
    wait_go(60, "rstwait_go_seen", lat);
    repeat (30) @(negedge iCLK);
    check("rstwait_in_wait_gnt", oGNT, 4'b0100);
    iRST_N = 1'b0;
    exp_q.delete();
    #1;
    check("rstwait_go_drop", oI2C_GO, 0);
    check("rstwait_gnt_drop", oGNT, 0);
    iREQ = 4'b0101;
    push(0, 0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    wait_go(60, "restart_go_seen", lat);
    check("restart_gnt", oGNT, 4'b0001);
    wait_empty(400, "restart_done");
    iREQ = 4'b0000;
    repeat (3 * PERIOD) @(negedge iCLK);
    check("final_busy", oBUSY, 0);
    check("final_go", oI2C_GO, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_ccd_write_arbiter.md
Name: i2c_ccd_write_arbiter

Overview:
- Shares the single sensor I2C_Controller between several requesters that write 16-bit sensor register words. Requesters include the power-up LUT sequencer, the runtime exposure/gain updater and the readout-mode/zoom updater.
- Generates the I2C control clock and drives the controller's GO/END/ACK handshake.
- Applies round-robin arbitration, NACK retry and END timeout.
- Sits between the CCD configuration logic and I2C_Controller in the D5M capture path.

Parameters:
- CLK_FREQ, 50000000, iCLK frequency in Hz.
- I2C_FREQ, 20000, control-clock toggle rate. The divider wraps at CLK_FREQ/I2C_FREQ.
- NUM_REQ, 4, number of requesters (2..8).
- SLAVE_ADDR, 8'hBA, sensor write address prepended to every word.
- MAX_RETRY, 3, re-issues allowed after a NACK or timeout.
- TIMEOUT_TICKS, 64, control-clock ticks to wait for END before treating the transfer as a NACK.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset; asynchronous, active-low; clock iCLK.
- iREQ  in  NUM_REQ  per-requester request level. Held until that requester's oDONE or oERR.
- iREQ_DATA  in  16*NUM_REQ  per-requester {sub_addr, data} word. Requester i uses bits [16i+15:16i]. Must be stable while iREQ[i] is high.
- oGNT  out  NUM_REQ  one-hot; high for the whole transaction, including retries.
- oDONE  out  NUM_REQ  one-iCLK pulse when the write is acknowledged.
- oERR  out  NUM_REQ  one-iCLK pulse when retries are exhausted.
- oBUSY  out  1  high whenever the FSM is not in IDLE.
- oI2C_CTRL_CLK  out  1  divided clock to I2C_Controller.CLOCK.
- oI2C_DATA  out  24  {SLAVE_ADDR, word} to the controller.
- oI2C_GO  out  1  transfer request to the controller.
- iI2C_END  in  1  transfer complete, from the controller.
- iI2C_ACK  in  1  from the controller. 0 means the slave acknowledged; 1 means NACK.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, rr_ptr 0, retry count 0, divider 0.
- Reset mid-transfer: oI2C_GO drops immediately and no oDONE/oERR is produced. The controller shares iRST_N.
- Divider counts 0..CLK_FREQ/I2C_FREQ, then wraps and toggles oI2C_CTRL_CLK.
- tick is high for one iCLK cycle when the wrap makes oI2C_CTRL_CLK go 0->1.
- FSM state, oI2C_DATA and oI2C_GO change only on tick cycles. iI2C_END and iI2C_ACK are sampled only on tick cycles.
- IDLE:
  - If iREQ is nonzero, grant the first set bit searching upward from rr_ptr with wrap-around.
  - Latch that requester's word, set oGNT, clear the retry count, go to ISSUE.
  - If iREQ is zero, stay in IDLE.
- ISSUE: oI2C_DATA={SLAVE_ADDR, latched word}, oI2C_GO=1, clear the timeout counter, go to WAIT.
- WAIT:
  - On END with ACK=0: oI2C_GO=0, pulse oDONE[g], go to GAP (done).
  - On END with ACK=1, or when the timeout counter reaches TIMEOUT_TICKS: oI2C_GO=0.
    - If retry < MAX_RETRY: retry+1, go to GAP (retry).
    - Otherwise: pulse oERR[g], go to GAP (done).
  - Otherwise: increment the timeout counter.
- GAP lasts exactly one tick with GO low.
  - Retry path: go to ISSUE with the same word.
  - Done path: clear oGNT, set rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
- Minimum GO-low time between transfers is one control-clock period.
- oDONE and oERR are asserted in the tick cycle only, so each is exactly one iCLK cycle wide.
- Latency: request to GO is at most 2 ticks when the arbiter is idle.
- iREQ[g] dropping mid-transaction is ignored: the transfer completes and its pulse is still issued.
- New requests that arrive during a transaction wait for IDLE.
- A requester that holds iREQ across its own oDONE is re-granted only after all other pending requesters (fairness).

Decomposition:
- Shared package:
  - FSM state enum: IDLE, ISSUE, WAIT, GAP.
  - Default constants: SENSOR_WR_ADDR=8'hBA, I2C word width 24, register word width 16.
- One sub-module, i2c_tick_gen: the divider that produces oI2C_CTRL_CLK and tick.

Test Plan:
- Single write: iREQ=4'b0001, word 16'h2000, slave returns ACK=0 -> GO seen with oI2C_DATA=24'hBA2000; oDONE[0] one-cycle pulse; oGNT back to 0; oBUSY low afterwards.
- Round-robin: iREQ=4'b1011 held, all ACK=0 -> grant order 0,1,3,0,1,3; rr_ptr wraps correctly.
- Retry: NACK on the first 2 ENDs then ACK=0, word 16'hF103 -> exactly 3 GO assertions, each separated by at least one control-clock period of GO low; then a single oDONE pulse.
- Exhausted: NACK always, MAX_RETRY=3 -> 4 GO assertions, oERR pulse; the next pending requester is served.
- Timeout: END never asserted -> oERR after 4 attempts of TIMEOUT_TICKS=64 ticks each.
- Reset during WAIT -> GO low in the same cycle; no DONE/ERR; after release, a pending request restarts from requester 0.
